alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
Sequencing stage directly upstream of the 16-bit adiabatic AND array.
- Accepts an operand pair over a valid/ready handshake and drives it onto the array inputs (op_a/op_b).
- Holds those inputs stable for the full multi-phase adiabatic evaluation window (HOLD_CYCLES).
- Captures the array output (and_res) and presents it downstream over a second valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width in bits.
HOLD_CYCLES, 4, clkpos cycles the operands are held before and_res is sampled; legal range 1..255, 0 is illegal.

Ports:
clkpos  input  1  sole clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
vdd  input  1  power pin, no logic function.
vss  input  1  ground pin, no logic function.
in_valid  input  1  operand pair valid.
in_ready  output  1  stage can accept an operand pair.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
op_a  output  WIDTH  registered operand A to the AND array.
op_b  output  WIDTH  registered operand B to the AND array.
and_res  input  WIDTH  AND array output.
res_valid  output  1  result valid.
res_ready  input  1  downstream accepts result.
res  output  WIDTH  registered result.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (next clkpos edge with reset=1): state=IDLE, hold counter=0, op_a=0, op_b=0, res=0, res_valid=0.
- Reset overrides all other inputs. Reset mid-operation abandons the operation; no res_valid is produced for it.
- in_ready = (state==IDLE). It is combinational from state only and never depends on in_valid.
- busy = (state != IDLE).
- Three states: IDLE, DRIVE, RESULT.
- IDLE -> DRIVE:
  - Transition when in_valid && in_ready.
  - op_a<=in_a, op_b<=in_b, counter<=0.
- DRIVE:
  - op_a/op_b held; counter increments each cycle.
  - On the edge where counter==HOLD_CYCLES-1: res<=and_res, res_valid<=1, state<=RESULT.
  - DRIVE therefore lasts exactly HOLD_CYCLES cycles.
- RESULT:
  - res and res_valid held stable until res_valid && res_ready.
  - On that edge: res_valid<=0, state<=IDLE. res keeps its last value.
- Latency: res_valid is first high HOLD_CYCLES+1 cycles after the input handshake cycle.
- Throughput: with res_ready tied high, one accept per HOLD_CYCLES+2 cycles.
- op_a/op_b change only on an input accept. They retain their values through RESULT and IDLE, so no needless switching of adiabatic nodes.
- Inputs with no effect:
  - in_valid while in_ready=0: ignored; upstream must hold its data.
  - res_ready while res_valid=0: ignored.
- No combinational path from in_* to op_* or res, and none from and_res to res. All outputs except in_ready/busy are registered.
- HOLD_CYCLES=1: DRIVE lasts one cycle; latency 2.

Optional Feature:
ALU_STAGE_CHECK_EN
- Defined:
  - Adds output chk_err (1 bit, reset value 0).
  - At the DRIVE->RESULT capture edge, and_res is compared with op_a & op_b; any mismatch sets chk_err.
  - chk_err is sticky and cleared only by reset.
- Not defined: chk_err port and comparator logic are absent. All other behaviour is identical.

Test Plan:
(all with WIDTH=16, HOLD_CYCLES=4, and_res modelled as op_a & op_b unless stated)
1. Reset, with in_valid=1 and in_a=0xFFFF held during reset -> op_a=op_b=res=0x0000, res_valid=0, busy=0, in_ready=1; nothing accepted.
2. Single op: in_a=0xF0F0, in_b=0xFF00, handshake at cycle T -> op_a=0xF0F0 from T+1, res=0xF000 and res_valid=1 at T+5, back in IDLE at T+6 with res_ready=1.
3. Backpressure: res_ready=0 for 3 cycles after res_valid, with in_valid=1 and new operands applied -> res stable at 0xF000, in_ready=0, op_a/op_b unchanged, new pair accepted only after the result handshake.
4. Back-to-back with in_valid and res_ready held high: pairs (0xFFFF,0x1234) then (0xAAAA,0x5555) -> res 0x1234 then 0x0000, accepts exactly 6 cycles apart.
5. Reset asserted in DRIVE with counter=2 -> IDLE on the next cycle, res_valid never rises, op_a=0.
6. With ALU_STAGE_CHECK_EN: and_res forced to 0xFFFF for op 0x0F0F/0x00FF -> chk_err=1 from the capture edge, stays 1 through later correct ops, clears on reset.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand sequencer for the 16-bit adiabatic AND array: accept, hold for HOLD_CYCLES, capture, hand off.
// Optional macro ALU_STAGE_CHECK_EN adds a sticky chk_err comparing and_res with op_a & op_b.
module alu_operand_stage #(
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clkpos,
  input  logic             reset,
  input  logic             vdd,
  input  logic             vss,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] and_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
`ifdef ALU_STAGE_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_e;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             chk_err_q, chk_err_d;

  // Supply pins carry no logic; fold them into a deliberately unused net.
  logic unused_pwr;
  assign unused_pwr = vdd ^ vss;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    chk_err_d   = chk_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          cnt_d   = 8'd0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          res_d       = and_res;
          res_valid_d = 1'b1;
          state_d     = RESULT;
`ifdef ALU_STAGE_CHECK_EN
          if (and_res != (op_a_q & op_b_q)) begin
            chk_err_d = 1'b1;
          end
`endif
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkpos) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;

`ifdef ALU_STAGE_CHECK_EN
  assign chk_err = chk_err_q;
`else
  logic unused_chk;
  assign unused_chk = chk_err_q;
`endif

endmodule
